// File: rtl/nibble_serial_subtractor.sv
// Bit-serial-by-nibble unsigned/two's-complement subtractor: latches an operand pair,
// ripples the borrow through one 4-bit slice per clock, then holds the result until it is taken.
module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned IW  = KW + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [IW-1:0]    base;
  logic [4:0]       nib_sub;
  logic             last_nib;

  // Next-state, datapath and flag computation
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    bin_d        = bin_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;

    base     = {k_q, 2'b00};
    nib_sub  = 5'(a_q[base +: 4]) - 5'(b_q[base +: 4]) - 5'(bin_q);
    last_nib = (k_q == KW'(NIB - 1));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a_in;
          b_d        = b_in;
          k_d        = '0;
          bin_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        diff_d[base +: 4] = nib_sub[3:0];
        bin_d             = nib_sub[4];
        k_d               = k_q + 1'b1;
        if (last_nib) begin
          // Flags are finalised together with the top nibble
          k_d          = '0;
          borrow_out_d = nib_sub[4];
          ovf_d        = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d       = (diff_d == '0);
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      bin_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      bin_q        <= bin_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH = 16).
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;
  logic        ovf;
  logic        zero;

  int errors;
  int checks;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepts one operand pair, waits for out_valid, returns outputs and latency in cycles (-1 on timeout).
  task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] d, output logic bo, output logic ov,
                                output logic z, output int lat);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid) begin
        lat = c - 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    d  = diff;
    bo = borrow_out;
    ov = ovf;
    z  = zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (diff !== 16'h0000 || borrow_out !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: diff=%h bo=%b ovf=%b zero=%b required 0000/0/0/0", diff, borrow_out, ovf, zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic ebo, input logic eov, input logic ez);
    logic [15:0] d; logic bo, ov, z; int lat;
    start_and_wait(a, b, d, bo, ov, z, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d required 4", name, lat);
    end
    checks++;
    if (d !== ed) begin
      errors++;
      $display("FAIL %s_diff: got %h required %h", name, d, ed);
    end
    checks++;
    if (bo !== ebo || ov !== eov || z !== ez) begin
      errors++;
      $display("FAIL %s_flags: bo/ovf/zero got %b%b%b required %b%b%b", name, bo, ov, z, ebo, eov, ez);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    check_op("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_borrow_ripple();
    check_op("ripple", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    check_op("ovf_neg", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    check_op("ovf_pos", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_zero();
    check_op("zero", 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int bad_ready;
    int bad_hold;
    bool_wait: begin end
    bad_ready = 0;
    bad_hold  = 0;
    a_in = 16'h1234; b_in = 16'h0234; in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep presenting different operands; they must be ignored
    a_in = 16'hFFFF; b_in = 16'h0000;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      if (in_ready !== 1'b0) bad_ready++;
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b required 1", out_valid);
    end
    for (int c = 0; c < 10; c++) begin
      if (in_ready !== 1'b0) bad_ready++;
      if (out_valid !== 1'b1 || diff !== 16'h1000 || borrow_out !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0)
        bad_hold++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL bp_in_ready: %0d busy cycles with in_ready high, required 0", bad_ready);
    end
    checks++;
    if (bad_hold != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, last diff=%h, required 0 (diff 1000)", bad_hold, diff);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    a_in = 16'h0000; b_in = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 16'h0000) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b in_ready=%b diff=%h required 0/1/0000", out_valid, in_ready, diff);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check_op("post_rst", 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_overflow();
    test_zero();
    test_backpressure();
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
